// File: rtl/nettlp_pkg.sv
// Shared types for the NetTLP TX path: grant states, source ids and TUSER width.
// Imported by the TX arbiter and its output skid buffer.
package nettlp_pkg;

    localparam int TUSER_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_APP,
        GRANT_INJ
    } grant_state_t;

    typedef enum logic {
        SRC_APP,
        SRC_INJ
    } src_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI4-Stream skid buffer with registered outputs and registered in_ready.
// Ports: clk/rst, in_* slave stream (in_ready out), out_* master stream (out_ready in).
module axis_skid_buf
    import nettlp_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [KEEP_WIDTH-1:0]  in_keep,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [TUSER_WIDTH-1:0] in_user,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [KEEP_WIDTH-1:0]  out_keep,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TUSER_WIDTH-1:0] out_user
);

    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + TUSER_WIDTH;

    logic [PW-1:0] head_q;
    logic [PW-1:0] spare_q;
    logic [PW-1:0] in_pld;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          push;
    logic          pop;

    assign in_pld    = {in_last, in_keep, in_data, in_user};
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign {out_last, out_keep, out_data, out_user} = head_q;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // head_q always holds the oldest beat; spare_q only fills while
    // the head is stalled, so a full buffer drops in_ready a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 2'd0;
            in_ready <= 1'b1;
            head_q   <= '0;
            spare_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            in_ready <= (cnt_d != 2'd2);
            if ((cnt_q == 2'd0 && push) ||
                (cnt_q == 2'd1 && push && pop)) begin
                head_q <= in_pld;
            end else if (cnt_q == 2'd2 && pop) begin
                head_q <= spare_q;
            end
            if (cnt_q == 2'd1 && push && !pop) begin
                spare_q <= in_pld;
            end
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic round-robin arbiter between the local PIO engine and injected TLPs.
// Ports: app_* and inj_* TX streams in, pcie_tx1_* stream to the core, per-source packet counters.
module pcie_tx_arbiter
    import nettlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst,
    input  logic                    app_tx_req,
    output logic                    app_tx_ack,
    output logic                    app_tx_tready,
    input  logic                    app_tx_tvalid,
    input  logic                    app_tx_tlast,
    input  logic [KEEP_WIDTH-1:0]   app_tx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] app_tx_tdata,
    input  logic [TUSER_WIDTH-1:0]  app_tx_tuser,
    output logic                    inj_tx_tready,
    input  logic                    inj_tx_tvalid,
    input  logic                    inj_tx_tlast,
    input  logic [KEEP_WIDTH-1:0]   inj_tx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] inj_tx_tdata,
    input  logic [TUSER_WIDTH-1:0]  inj_tx_tuser,
    input  logic                    pcie_tx1_tready,
    output logic                    pcie_tx1_tvalid,
    output logic                    pcie_tx1_tlast,
    output logic [KEEP_WIDTH-1:0]   pcie_tx1_tkeep,
    output logic [C_DATA_WIDTH-1:0] pcie_tx1_tdata,
    output logic [TUSER_WIDTH-1:0]  pcie_tx1_tuser,
    output logic [31:0]             cnt_app_pkts,
    output logic [31:0]             cnt_inj_pkts
);

    grant_state_t state_q;
    grant_state_t state_d;
    src_t         last_win_q;
    src_t         last_win_d;

    logic                    skid_in_ready;
    logic                    skid_in_valid;
    logic                    skid_in_last;
    logic [KEEP_WIDTH-1:0]   skid_in_keep;
    logic [C_DATA_WIDTH-1:0] skid_in_data;
    logic [TUSER_WIDTH-1:0]  skid_in_user;
    logic                    app_eop;
    logic                    inj_eop;

    assign app_tx_ack    = (state_q == GRANT_APP);
    assign app_tx_tready = (state_q == GRANT_APP) && skid_in_ready;
    assign inj_tx_tready = (state_q == GRANT_INJ) && skid_in_ready;

    assign app_eop = app_tx_tready && app_tx_tvalid && app_tx_tlast;
    assign inj_eop = inj_tx_tready && inj_tx_tvalid && inj_tx_tlast;

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q    <= IDLE;
            last_win_q <= SRC_INJ;
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
        end
    end

    // Every grant updates last_win, so a tie goes to whichever
    // source was not served most recently.
    always_comb begin
        state_d    = state_q;
        last_win_d = last_win_q;
        unique case (state_q)
            IDLE: begin
                if (app_tx_req && inj_tx_tvalid) begin
                    if (last_win_q == SRC_INJ) begin
                        state_d    = GRANT_APP;
                        last_win_d = SRC_APP;
                    end else begin
                        state_d    = GRANT_INJ;
                        last_win_d = SRC_INJ;
                    end
                end else if (app_tx_req) begin
                    state_d    = GRANT_APP;
                    last_win_d = SRC_APP;
                end else if (inj_tx_tvalid) begin
                    state_d    = GRANT_INJ;
                    last_win_d = SRC_INJ;
                end
            end
            GRANT_APP: begin
                if (app_eop) begin
                    state_d = IDLE;
                end
            end
            GRANT_INJ: begin
                if (inj_eop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        skid_in_valid = 1'b0;
        skid_in_last  = 1'b0;
        skid_in_keep  = '0;
        skid_in_data  = '0;
        skid_in_user  = '0;
        unique case (state_q)
            GRANT_APP: begin
                skid_in_valid = app_tx_tvalid;
                skid_in_last  = app_tx_tlast;
                skid_in_keep  = app_tx_tkeep;
                skid_in_data  = app_tx_tdata;
                skid_in_user  = app_tx_tuser;
            end
            GRANT_INJ: begin
                skid_in_valid = inj_tx_tvalid;
                skid_in_last  = inj_tx_tlast;
                skid_in_keep  = inj_tx_tkeep;
                skid_in_data  = inj_tx_tdata;
                skid_in_user  = inj_tx_tuser;
            end
            default: begin
                skid_in_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            cnt_app_pkts <= 32'd0;
            cnt_inj_pkts <= 32'd0;
        end else begin
            if (app_eop) begin
                cnt_app_pkts <= cnt_app_pkts + 32'd1;
            end
            if (inj_eop) begin
                cnt_inj_pkts <= cnt_inj_pkts + 32'd1;
            end
        end
    end

    axis_skid_buf #(
        .DATA_WIDTH (C_DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_skid (
        .clk       (pcie_clk),
        .rst       (pcie_rst),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_last   (skid_in_last),
        .in_keep   (skid_in_keep),
        .in_data   (skid_in_data),
        .in_user   (skid_in_user),
        .out_valid (pcie_tx1_tvalid),
        .out_ready (pcie_tx1_tready),
        .out_last  (pcie_tx1_tlast),
        .out_keep  (pcie_tx1_tkeep),
        .out_data  (pcie_tx1_tdata),
        .out_user  (pcie_tx1_tuser)
    );

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomised and directed bench for pcie_tx_arbiter.
// A queue-based model predicts every output each cycle.
module tb_pcie_tx_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [3:0]    user;
    } beat_t;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst = 1'b1;
    logic          app_tx_req = 1'b0;
    logic          app_tx_ack;
    logic          app_tx_tready;
    logic          app_tx_tvalid = 1'b0;
    logic          app_tx_tlast = 1'b0;
    logic [KW-1:0] app_tx_tkeep = '0;
    logic [DW-1:0] app_tx_tdata = '0;
    logic [3:0]    app_tx_tuser = '0;
    logic          inj_tx_tready;
    logic          inj_tx_tvalid = 1'b0;
    logic          inj_tx_tlast = 1'b0;
    logic [KW-1:0] inj_tx_tkeep = '0;
    logic [DW-1:0] inj_tx_tdata = '0;
    logic [3:0]    inj_tx_tuser = '0;
    logic          pcie_tx1_tready = 1'b0;
    logic          pcie_tx1_tvalid;
    logic          pcie_tx1_tlast;
    logic [KW-1:0] pcie_tx1_tkeep;
    logic [DW-1:0] pcie_tx1_tdata;
    logic [3:0]    pcie_tx1_tuser;
    logic [31:0]   cnt_app_pkts;
    logic [31:0]   cnt_inj_pkts;

    pcie_tx_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .pcie_clk        (pcie_clk),
        .pcie_rst        (pcie_rst),
        .app_tx_req      (app_tx_req),
        .app_tx_ack      (app_tx_ack),
        .app_tx_tready   (app_tx_tready),
        .app_tx_tvalid   (app_tx_tvalid),
        .app_tx_tlast    (app_tx_tlast),
        .app_tx_tkeep    (app_tx_tkeep),
        .app_tx_tdata    (app_tx_tdata),
        .app_tx_tuser    (app_tx_tuser),
        .inj_tx_tready   (inj_tx_tready),
        .inj_tx_tvalid   (inj_tx_tvalid),
        .inj_tx_tlast    (inj_tx_tlast),
        .inj_tx_tkeep    (inj_tx_tkeep),
        .inj_tx_tdata    (inj_tx_tdata),
        .inj_tx_tuser    (inj_tx_tuser),
        .pcie_tx1_tready (pcie_tx1_tready),
        .pcie_tx1_tvalid (pcie_tx1_tvalid),
        .pcie_tx1_tlast  (pcie_tx1_tlast),
        .pcie_tx1_tkeep  (pcie_tx1_tkeep),
        .pcie_tx1_tdata  (pcie_tx1_tdata),
        .pcie_tx1_tuser  (pcie_tx1_tuser),
        .cnt_app_pkts    (cnt_app_pkts),
        .cnt_inj_pkts    (cnt_inj_pkts)
    );

    always #5 pcie_clk = ~pcie_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    beat_t app_q[$];
    beat_t inj_q[$];
    beat_t mq[$];
    beat_t out_q[$];
    bit    app_hold = 0;
    bit    inj_hold = 0;
    bit    app_started = 0;

    // model: owner 0=none 1=app 2=inj; last winner 1/2
    int          m_owner = 0;
    int          m_last = 2;
    logic [31:0] m_cnt_app = '0;
    logic [31:0] m_cnt_inj = '0;
    bit          m_rst = 1;

    int p_valid = 100;
    int p_tready = 100;
    int p_req = 100;
    int stall_from = -1;
    int stall_to = -1;

    logic        lg_ack [64];
    logic        lg_irdy[64];
    logic        lg_tv  [64];
    logic        lg_tl  [64];
    logic [31:0] lg_ca  [64];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int len,
                           input logic [63:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? {$urandom, $urandom} : base + 64'(i);
            b.keep = rnd ? 8'($urandom) : 8'hFF;
            b.user = rnd ? 4'($urandom) : 4'(i);
            b.last = (i == len - 1);
            if (src == 1) app_q.push_back(b);
            else inj_q.push_back(b);
        end
    endtask

    task automatic model_update();
        bit full;
        bit push_a;
        bit push_i;
        bit a;
        bit i;
        if (pcie_rst) begin
            m_owner = 0;
            m_last = 2;
            mq.delete();
            m_cnt_app = '0;
            m_cnt_inj = '0;
            m_rst = 1;
            app_q.delete();
            inj_q.delete();
            app_hold = 0;
            inj_hold = 0;
            app_started = 0;
        end else begin
            m_rst = 0;
            full = (mq.size() >= 2);
            push_a = (m_owner == 1) && app_tx_tvalid && !full;
            push_i = (m_owner == 2) && inj_tx_tvalid && !full;
            if (mq.size() > 0 && pcie_tx1_tready) void'(mq.pop_front());
            if (push_a) begin
                mq.push_back(app_q[0]);
                app_started = !app_q[0].last;
                if (app_q[0].last) begin
                    m_cnt_app = m_cnt_app + 1;
                    m_owner = 0;
                end
                void'(app_q.pop_front());
                app_hold = 0;
            end else if (push_i) begin
                mq.push_back(inj_q[0]);
                if (inj_q[0].last) begin
                    m_cnt_inj = m_cnt_inj + 1;
                    m_owner = 0;
                end
                void'(inj_q.pop_front());
                inj_hold = 0;
            end else if (m_owner == 0) begin
                a = app_tx_req;
                i = inj_tx_tvalid;
                if (a && i) m_owner = (m_last == 2) ? 1 : 2;
                else if (a) m_owner = 1;
                else if (i) m_owner = 2;
                if (m_owner != 0) m_last = m_owner;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ack", app_tx_ack, m_owner == 1);
        chk("app_tready", app_tx_tready, (m_owner == 1) && (mq.size() < 2));
        chk("inj_tready", inj_tx_tready, (m_owner == 2) && (mq.size() < 2));
        chk("tvalid", pcie_tx1_tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("tdata", pcie_tx1_tdata, mq[0].data);
            chk("tkeep", pcie_tx1_tkeep, mq[0].keep);
            chk("tlast", pcie_tx1_tlast, mq[0].last);
            chk("tuser", pcie_tx1_tuser, mq[0].user);
        end else if (m_rst) begin
            chk("rst_payload",
                {pcie_tx1_tlast, pcie_tx1_tkeep, pcie_tx1_tuser, pcie_tx1_tdata},
                64'd0);
        end
        chk("cnt_app", cnt_app_pkts, m_cnt_app);
        chk("cnt_inj", cnt_inj_pkts, m_cnt_inj);
    endtask

    task automatic drive_inputs();
        beat_t z;
        z = '0;
        app_tx_tvalid = (app_q.size() > 0) &&
                        (app_hold || ($urandom_range(99) < p_valid));
        app_hold = app_tx_tvalid;
        {app_tx_tdata, app_tx_tkeep, app_tx_tlast, app_tx_tuser} =
            (app_q.size() > 0) ? app_q[0] : z;
        app_tx_req = app_started ? ($urandom_range(99) < p_req)
                                 : (app_q.size() > 0);
        inj_tx_tvalid = (inj_q.size() > 0) &&
                        (inj_hold || ($urandom_range(99) < p_valid));
        inj_hold = inj_tx_tvalid;
        {inj_tx_tdata, inj_tx_tkeep, inj_tx_tlast, inj_tx_tuser} =
            (inj_q.size() > 0) ? inj_q[0] : z;
        if (cyc >= stall_from && cyc <= stall_to) pcie_tx1_tready = 1'b0;
        else pcie_tx1_tready = ($urandom_range(99) < p_tready);
        if (pcie_tx1_tvalid && pcie_tx1_tready)
            out_q.push_back({pcie_tx1_tdata, pcie_tx1_tkeep,
                             pcie_tx1_tlast, pcie_tx1_tuser});
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        model_update();
        @(negedge pcie_clk);
        cyc++;
        check_outputs();
        if (cyc < 64) begin
            lg_ack[cyc]  = app_tx_ack;
            lg_irdy[cyc] = inj_tx_tready;
            lg_tv[cyc]   = pcie_tx1_tvalid;
            lg_tl[cyc]   = pcie_tx1_tlast;
            lg_ca[cyc]   = cnt_app_pkts;
        end
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        pcie_rst = 1'b1;
        drive_inputs();
        run(2);
        pcie_rst = 1'b0;
        drive_inputs();
    endtask

    task automatic start();
        cyc = 0;
        out_q.delete();
        drive_inputs();
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        drive_inputs();
        do_reset();
        chk("rst_ack", app_tx_ack, 0);
        chk("rst_app_rdy", app_tx_tready, 0);
        chk("rst_inj_rdy", inj_tx_tready, 0);
        chk("rst_tvalid", pcie_tx1_tvalid, 0);
        chk("rst_tdata", pcie_tx1_tdata, 0);
        chk("rst_cnt_app", cnt_app_pkts, 0);
        chk("rst_cnt_inj", cnt_inj_pkts, 0);

        // single inj packet, 3 beats
        add_pkt(2, 3, 64'h100, 0);
        start();
        run(7);
        chk("A_inj_rdy1", lg_irdy[1], 1);
        chk("A_tv1", lg_tv[1], 0);
        for (int c = 2; c <= 4; c++) chk("A_tv", lg_tv[c], 1);
        chk("A_tl3", lg_tl[3], 0);
        chk("A_tl4", lg_tl[4], 1);
        chk("A_tv5", lg_tv[5], 0);
        chk("A_cnt_inj", cnt_inj_pkts, 1);
        for (int c = 1; c <= 7; c++) chk("A_ack", lg_ack[c], 0);
        chk("A_nbeats", out_q.size(), 3);

        // simultaneous requests after reset
        do_reset();
        add_pkt(1, 2, 64'hA0, 0);
        add_pkt(2, 2, 64'hB0, 0);
        start();
        run(8);
        chk("B_ack1", lg_ack[1], 1);
        chk("B_tv2", lg_tv[2], 1);
        chk("B_tv3", lg_tv[3], 1);
        chk("B_gap4", lg_tv[4], 0);
        chk("B_tv5", lg_tv[5], 1);
        chk("B_tv6", lg_tv[6], 1);
        chk("B_nbeats", out_q.size(), 4);
        if (out_q.size() == 4) begin
            chk("B_d0", out_q[0].data, 64'hA0);
            chk("B_d1", out_q[1].data, 64'hA1);
            chk("B_d2", out_q[2].data, 64'hB0);
            chk("B_d3", out_q[3].data, 64'hB1);
        end
        add_pkt(1, 1, 64'hA8, 0);
        add_pkt(2, 1, 64'hB8, 0);
        start();
        run(1);
        chk("B_second_app_wins", lg_ack[1], 1);
        chk("B_second_inj_wait", lg_irdy[1], 0);
        run(10);

        // core stalls for 5 cycles mid-packet
        do_reset();
        stall_from = 5;
        stall_to = 9;
        add_pkt(2, 16, 64'h0, 0);
        start();
        run(30);
        stall_from = -1;
        stall_to = -1;
        for (int c = 7; c <= 9; c++) begin
            chk("C_inj_rdy_stall", lg_irdy[c], 0);
            chk("C_tv_stall", lg_tv[c], 1);
        end
        chk("C_nbeats", out_q.size(), 16);
        for (int k = 0; k < 16 && k < out_q.size(); k++) begin
            chk("C_data", out_q[k].data, 64'(k));
            chk("C_user", out_q[k].user, 64'(k % 16));
        end

        // app drops req after the first beat
        do_reset();
        p_req = 0;
        add_pkt(1, 4, 64'hD0, 0);
        start();
        run(7);
        p_req = 100;
        for (int c = 1; c <= 4; c++) chk("D_ack_held", lg_ack[c], 1);
        chk("D_ack_drop", lg_ack[5], 0);
        chk("D_cnt_app", lg_ca[6], 1);

        // reset during beat 2 of 4
        add_pkt(1, 4, 64'hE0, 0);
        start();
        run(2);
        pcie_rst = 1'b1;
        run(1);
        chk("E_tv", lg_tv[3], 0);
        chk("E_ack", lg_ack[3], 0);
        chk("E_cnt_app", lg_ca[3], 0);
        pcie_rst = 1'b0;
        out_q.delete();
        add_pkt(2, 2, 64'hE8, 0);
        drive_inputs();
        run(8);
        chk("E_nbeats", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("E_d0", out_q[0].data, 64'hE8);
            chk("E_d1", out_q[1].data, 64'hE9);
        end
        chk("E_cnt_inj", cnt_inj_pkts, 1);
        chk("E_cnt_app_after", cnt_app_pkts, 0);

        // inj counter wrap
        force dut.cnt_inj_pkts = 32'hFFFF_FFFF;
        m_cnt_inj = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_inj_pkts;
        chk("F_preload", cnt_inj_pkts, 32'hFFFF_FFFF);
        add_pkt(2, 1, 64'hF0, 0);
        drive_inputs();
        run(6);
        chk("F_wrap", cnt_inj_pkts, 0);

        // randomised traffic
        do_reset();
        p_valid = 70;
        p_tready = 70;
        p_req = 50;
        repeat (3000) begin
            if (app_q.size() == 0 && $urandom_range(3) == 0)
                add_pkt(1, int'($urandom_range(1, 5)), 64'h0, 1);
            if (inj_q.size() == 0 && $urandom_range(3) == 0)
                add_pkt(2, int'($urandom_range(1, 5)), 64'h0, 1);
            if ($urandom_range(499) == 0) begin
                pcie_rst = 1'b1;
                run(1);
                pcie_rst = 1'b0;
            end
            run(1);
        end
        p_valid = 100;
        p_tready = 100;
        p_req = 100;
        run(50);
        chk("R_drained", mq.size() + app_q.size() + inj_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
